mem_rsp: RTL and testbench

Single-port memory responder on the core's request/response bus: the target side for the instruction-fetch and load/store initiators. It accepts one request at a time, waits a configurable number of cycles to model memory latency, then commits the write or returns read data on a valid/ready response channel. It replaces DPI-backed memory in synthesizable builds and sits between the core's bus initiator and on-chip SRAM.

---
 rtl/mem_rsp.sv | 134 +++++++++++++
 tb/tb_mem_rsp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_rsp.sv
// ---------------------------------------------------------------------------
// mem_rsp: single-outstanding memory responder for the core request/response
// bus. A request is accepted in IDLE, held for LATENCY wait cycles, then the
// access happens on the edge that enters RESP. The response stays up until the
// initiator takes it.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_req_valid        request present
//   o_req_ready        responder can accept (IDLE only)
//   i_req_wen          1 = write, 0 = read
//   i_req_addr         byte address, bits [2:0] ignored
//   i_req_wdata        write data
//   i_req_wstrb        write byte enables
//   o_rsp_valid        response present
//   i_rsp_ready        initiator accepts response
//   o_rsp_rdata        read data, 0 for writes and errors
//   o_rsp_err          address out of range
// ---------------------------------------------------------------------------
module mem_rsp #(
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 64,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
    parameter int                LATENCY    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_wen,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wstrb,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                lat_wen;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [STRB_W-1:0]   lat_wstrb;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Word offset from the base; the >= test on the full address catches
    // anything below the base, so the subtraction's wrap never matters.
    logic [ADDR_W-4:0]     woff;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  access;
    logic                  mem_we;

    assign woff     = lat_addr[ADDR_W-1:3] - BASE_ADDR[ADDR_W-1:3];
    assign idx      = woff[DEPTH_LOG2-1:0];
    assign in_range = (lat_addr >= BASE_ADDR) && (woff[ADDR_W-4:DEPTH_LOG2] == '0);

    // The edge leaving WAIT with an exhausted counter is the edge entering RESP.
    assign access   = (state == WAIT) && (cnt == 4'd0);
    // Reset on the same edge suppresses the commit, so a pending write is dropped.
    assign mem_we   = i_rst_n && access && lat_wen && in_range;

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (lat_wstrb[b]) mem[idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            lat_wen     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_req_ready <= 1'b1;
                    if (i_req_valid && o_req_ready) begin
                        lat_wen     <= i_req_wen;
                        lat_addr    <= i_req_addr;
                        lat_wdata   <= i_req_wdata;
                        lat_wstrb   <= i_req_wstrb;
                        o_req_ready <= 1'b0;
                        // Counter holds the number of WAIT edges still to burn;
                        // with LATENCY=0 the very next edge is the access edge.
                        cnt         <= 4'(LATENCY);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= !in_range;
                        o_rsp_rdata <= (!lat_wen && in_range) ? mem[idx] : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= '0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rsp.sv
// ---------------------------------------------------------------------------
// tb_mem_rsp: directed self-checking bench for mem_rsp with default
// parameters (LATENCY=2, DEPTH_LOG2=12, BASE 0x8000_0000).
// ---------------------------------------------------------------------------
module tb_mem_rsp;

    localparam int LAT = 2;
    localparam int TMO = 50;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_wen;
    logic [63:0] i_req_addr;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mem_rsp #(
        .ADDR_W(64), .DATA_W(64), .DEPTH_LOG2(12),
        .BASE_ADDR(64'h8000_0000), .LATENCY(LAT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wen(i_req_wen), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one transaction with i_rsp_ready held high. Request inputs are
    // scrambled right after the accept edge. lat = edges after accept until
    // o_rsp_valid is seen.
    task automatic do_txn(input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb,
                          output logic [63:0] rdata, output logic err,
                          output int lat, output bit tmo);
        int w;
        tmo = 0; lat = 0; w = 0; rdata = '0; err = 1'b0;
        i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr;
        i_req_wdata = wdata; i_req_wstrb = wstrb; i_rsp_ready = 1'b1;
        while (!o_req_ready && w < TMO) begin tick(); w++; end
        if (!o_req_ready) tmo = 1;
        if (!tmo) begin
            tick(); // accept edge
            i_req_valid = 1'b0; i_req_wen = ~wen; i_req_addr = addr ^ 64'h18;
            i_req_wdata = ~wdata; i_req_wstrb = ~wstrb;
            while (!o_rsp_valid && lat < TMO) begin tick(); lat++; end
            if (!o_rsp_valid) tmo = 1;
            rdata = o_rsp_rdata;
            err   = o_rsp_err;
            tick(); // response handshake
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0;
        i_req_wdata = '0; i_req_wstrb = '0; i_rsp_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", o_req_ready); end
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_rsp_valid); end
        checks++; if (o_rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", o_rsp_rdata); end
        checks++; if (o_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_rsp_err); end
        i_rst_n = 1'b1;
        tick();
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", o_req_ready); end
    endtask

    task automatic test_read_latency();
        i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = 64'h8000_0000;
        i_rsp_ready = 1'b0;
        tick(); // accept edge N
        i_req_valid = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_early k=%0d got=%b exp=0", k, o_rsp_valid); end
            checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_busy k=%0d got=%b exp=0", k, o_req_ready); end
            tick();
        end
        // now after edge N+LAT+1
        checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", o_rsp_valid); end
        checks++; if (o_rsp_err !== 1'b0) begin errors++; $display("FAIL lat_err got=%b exp=0", o_rsp_err); end
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_resp got=%b exp=0", o_req_ready); end
        i_rsp_ready = 1'b1;
        tick();
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_clear got=%b exp=0", o_rsp_valid); end
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_back got=%b exp=1", o_req_ready); end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat; bit tmo;
        do_txn(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, rd, er, lat, tmo);
        checks++; if (tmo || er !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL wr_full_rsp tmo=%0d err=%b rdata=%h exp err=0 rdata=0", tmo, er, rd); end
        checks++; if (lat != LAT + 1) begin errors++; $display("FAIL wr_full_latency got=%0d exp=%0d", lat, LAT + 1); end
        do_txn(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'h1122334455667788 || er !== 1'b0) begin errors++; $display("FAIL rd_full got=%h err=%b exp=1122334455667788 err=0", rd, er); end
        // addr bits [2:0] ignored
        do_txn(1'b0, 64'h8000_0015, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'h1122334455667788) begin errors++; $display("FAIL rd_unaligned got=%h exp=1122334455667788", rd); end
    endtask

    task automatic test_partial_strobe();
        logic [63:0] rd; logic er; int lat; bit tmo;
        do_txn(1'b1, 64'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, er, lat, tmo);
        checks++; if (tmo || er !== 1'b0) begin errors++; $display("FAIL wr_partial_rsp tmo=%0d err=%b exp err=0", tmo, er); end
        do_txn(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL rd_partial got=%h exp=11223344aaaaaaaa", rd); end
        do_txn(1'b1, 64'h8000_0010, 64'h5555555555555555, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || er !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL wr_zero_strb_rsp err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        do_txn(1'b0, 64'h8000_0010, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL rd_zero_strb got=%h exp=11223344aaaaaaaa", rd); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic er; int lat; bit tmo;
        do_txn(1'b1, 64'h8000_0000, 64'hCAFEF00DDEADBEEF, 8'hFF, rd, er, lat, tmo);
        do_txn(1'b1, 64'h8000_7FF8, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er, lat, tmo);
        checks++; if (tmo || er !== 1'b0) begin errors++; $display("FAIL wr_last_word err=%b exp=0", er); end
        do_txn(1'b0, 64'h8000_7FF8, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'h0F0E0D0C0B0A0908 || er !== 1'b0) begin errors++; $display("FAIL rd_last_word got=%h err=%b exp=0f0e0d0c0b0a0908 err=0", rd, er); end
        do_txn(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || er !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL rd_below_base err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        do_txn(1'b1, 64'h8000_8000, 64'h1234123412341234, 8'hFF, rd, er, lat, tmo);
        checks++; if (tmo || er !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL wr_above_top err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        do_txn(1'b0, 64'h8000_0000, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'hCAFEF00DDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL rd_word0_unchanged got=%h err=%b exp=cafef00ddeadbeef err=0", rd, er); end
    endtask

    task automatic test_backpressure();
        int w;
        i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = 64'h8000_0010;
        i_rsp_ready = 1'b0;
        tick(); // accept (ready is 1 here after previous handshake)
        i_req_valid = 1'b0;
        w = 0;
        while (!o_rsp_valid && w < TMO) begin tick(); w++; end
        checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b exp=1", o_rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 64'h11223344AAAAAAAA ||
                o_rsp_err !== 1'b0 || o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold k=%0d valid=%b rdata=%h err=%b ready=%b exp 1/11223344aaaaaaaa/0/0",
                         k, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready);
            end
        end
        i_rsp_ready = 1'b1;
        tick();
        checks++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 64'h0 || o_req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release valid=%b rdata=%h ready=%b exp 0/0/1", o_rsp_valid, o_rsp_rdata, o_req_ready);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] rd; logic er; int lat; bit tmo;
        do_txn(1'b1, 64'h8000_0020, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat, tmo);
        i_req_valid = 1'b1; i_req_wen = 1'b1; i_req_addr = 64'h8000_0020;
        i_req_wdata = 64'hDEADDEADDEADDEAD; i_req_wstrb = 8'hFF; i_rsp_ready = 1'b1;
        tick(); // accept, now in WAIT
        i_req_valid = 1'b0;
        i_rst_n = 1'b0;
        tick();
        checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_reset valid=%b ready=%b exp 0/0", o_rsp_valid, o_req_ready); end
        i_rst_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_rsp k=%0d valid=%b exp=0", k, o_rsp_valid); end
        end
        do_txn(1'b0, 64'h8000_0020, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin errors++; $display("FAIL midrst_read got=%h err=%b exp=0123456789abcdef err=0", rd, er); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd; logic er; int lat; bit tmo;
        do_txn(1'b1, 64'h8000_0038, 64'hA5A5A5A5A5A5A5A5, 8'hF0, rd, er, lat, tmo);
        // ready must be back immediately after the handshake edge
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", o_req_ready); end
        do_txn(1'b1, 64'h8000_0038, 64'h0000000012345678, 8'h0F, rd, er, lat, tmo);
        do_txn(1'b0, 64'h8000_0038, 64'h0, 8'h00, rd, er, lat, tmo);
        checks++; if (tmo || rd !== 64'hA5A5A5A512345678) begin errors++; $display("FAIL b2b_read got=%h exp=a5a5a5a512345678", rd); end
        checks++; if (lat != LAT + 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, LAT + 1); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_read();
        test_partial_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
